// File: rtl/display_scan_sequencer.sv
// Multiplexed 4-digit 7-segment scan sequencer with PWM brightness.
// Each digit period is 8 phases of PHASE_CYCLES clocks. A lit frame is sent
// first; a blank frame follows once the lit phases have elapsed, and the
// next digit is loaded at the end of the period. Frames go out over a
// valid/ready handshake.
module display_scan_sequencer #(
  parameter int unsigned PHASE_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  digit0_i,
  input  logic [3:0]  digit1_i,
  input  logic [3:0]  digit2_i,
  input  logic [3:0]  digit3_i,
  input  logic        colon_i,
  input  logic [2:0]  brightness_i,
  input  logic [3:0]  blink_mask_i,
  input  logic        blink_phase_i,
  output logic [15:0] frame_o,
  output logic        frame_valid_o,
  input  logic        frame_ready_i,
  output logic [1:0]  digit_o,
  output logic        scan_wrap_o
);

  localparam int unsigned PERIOD      = 8 * PHASE_CYCLES;
  localparam int unsigned CNT_W       = $clog2(PERIOD + 1);
  localparam logic [CNT_W:0] PERIOD_C = (CNT_W + 1)'(PERIOD);
  localparam logic [15:0] BLANK_FRAME = 16'h00FF;

  typedef enum logic [1:0] {ST_LOAD, ST_ON, ST_BLANK, ST_OFF} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [2:0]       bright_q, bright_d;
  logic [15:0]      frame_q, frame_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic [1:0]       load_idx_c;
  logic [3:0]       load_val_c;
  logic [7:0]       load_seg_c;
  logic [15:0]      lit_frame_c;
  logic [CNT_W:0]   cnt_nxt_c;
  logic [CNT_W:0]   on_limit_c;
  logic             period_end_c;

  // BCD to segments {g..a}; 10-15 are blank
  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    case (val)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Lit frame for the digit about to be loaded, built from live inputs;
  // it is only captured into frame_q on LOAD entry, which forms the snapshot
  always_comb begin
    load_idx_c = (state_q == ST_LOAD) ? digit_q : digit_q + 2'd1;
    case (load_idx_c)
      2'd0:    load_val_c = digit0_i;
      2'd1:    load_val_c = digit1_i;
      2'd2:    load_val_c = digit2_i;
      default: load_val_c = digit3_i;
    endcase
    load_seg_c = {(load_idx_c == 2'd1) && colon_i, seg_decode(load_val_c)};
    if (blink_mask_i[load_idx_c] && blink_phase_i) begin
      load_seg_c = 8'h00;
    end
    lit_frame_c = {load_seg_c, 4'hF, ~(4'b0001 << load_idx_c)};
  end

  // Next-state and output logic; cnt holds the cycles elapsed since the
  // start of the lit-frame transfer cycle and saturates at the period length
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    bright_d     = bright_q;
    frame_d      = frame_q;
    valid_d      = valid_q;
    wrap_d       = 1'b0;
    period_end_c = 1'b0;
    cnt_nxt_c    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    on_limit_c   = (CNT_W + 1)'((32'(bright_q) + 32'd1) * PHASE_CYCLES);
    cnt_d        = (cnt_nxt_c <= PERIOD_C) ? CNT_W'(cnt_nxt_c) : cnt_q;

    case (state_q)
      ST_LOAD: begin
        cnt_d = '0;
        if (!valid_q) begin
          // first load after reset
          frame_d  = lit_frame_c;
          valid_d  = 1'b1;
          bright_d = brightness_i;
        end else if (frame_ready_i) begin
          cnt_d   = CNT_W'(1);
          valid_d = 1'b0;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (bright_q == 3'd7) begin
          period_end_c = (cnt_nxt_c >= PERIOD_C);
        end else if (cnt_nxt_c >= on_limit_c) begin
          frame_d = BLANK_FRAME;
          valid_d = 1'b1;
          state_d = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (frame_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        period_end_c = (cnt_nxt_c >= PERIOD_C);
      end
      default: state_d = ST_LOAD;
    endcase

    if (period_end_c) begin
      state_d  = ST_LOAD;
      digit_d  = digit_q + 2'd1;
      wrap_d   = (digit_q == 2'd3);
      frame_d  = lit_frame_c;
      valid_d  = 1'b1;
      bright_d = brightness_i;
      cnt_d    = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      digit_q  <= 2'd0;
      bright_q <= 3'd0;
      frame_q  <= BLANK_FRAME;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      bright_q <= bright_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign frame_o       = frame_q;
  assign frame_valid_o = valid_q;
  assign digit_o       = digit_q;
  assign scan_wrap_o   = wrap_q;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed test for display_scan_sequencer with PHASE_CYCLES=4.
module tb_display_scan_sequencer;

  localparam int unsigned P = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  d0, d1, d2, d3;
  logic        colon;
  logic [2:0]  bri;
  logic [3:0]  bmask;
  logic        bphase;
  logic        ready;
  logic [15:0] frame_o;
  logic        frame_valid_o;
  logic [1:0]  digit_o;
  logic        scan_wrap_o;

  int total = 0;
  int bad   = 0;

  display_scan_sequencer #(.PHASE_CYCLES(P)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .digit0_i      (d0),
    .digit1_i      (d1),
    .digit2_i      (d2),
    .digit3_i      (d3),
    .colon_i       (colon),
    .brightness_i  (bri),
    .blink_mask_i  (bmask),
    .blink_phase_i (bphase),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (ready),
    .digit_o       (digit_o),
    .scan_wrap_o   (scan_wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until frame_valid_o is seen (bounded); n = cycles advanced
  task automatic next_valid(output int n, output logic [15:0] f);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_valid_o && n < 200);
    if (!frame_valid_o) check("valid_timeout", 32'(frame_valid_o), 32'd1);
    f = frame_o;
  endtask

  // Hold reset for two cycles, release mid-cycle
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int          n;
  int          cnt;
  logic [15:0] f;
  logic [15:0] exp_seq [4];

  initial begin
    rst_n  = 1'b0;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    colon  = 1'b0;
    bri    = 3'd3;
    bmask  = 4'b0000;
    bphase = 1'b0;
    ready  = 1'b1;
    exp_seq[0] = 16'h5BFD;
    exp_seq[1] = 16'h4FFB;
    exp_seq[2] = 16'h66F7;
    exp_seq[3] = 16'h06FE;

    // Reset values and first lit frame, brightness 3
    tick();
    check("rst_frame", 32'(frame_o), 32'h00FF);
    check("rst_valid", 32'(frame_valid_o), 32'd0);
    check("rst_digit", 32'(digit_o), 32'd0);
    check("rst_wrap", 32'(scan_wrap_o), 32'd0);
    do_reset();
    tick();
    check("b3_lit0_valid", 32'(frame_valid_o), 32'd1);
    check("b3_lit0_frame", 32'(frame_o), 32'h06FE);
    check("b3_lit0_digit", 32'(digit_o), 32'd0);
    tick();
    check("b3_lit0_drop", 32'(frame_valid_o), 32'd0);
    next_valid(n, f);
    check("b3_blank_delay", 32'(n), 32'd15);
    check("b3_blank_frame", 32'(f), 32'h00FF);
    next_valid(n, f);
    check("b3_lit1_delay", 32'(n), 32'd16);
    check("b3_lit1_frame", 32'(f), 32'h5BFD);
    check("b3_lit1_digit", 32'(digit_o), 32'd1);

    // Full duty: no blank frames, 32-cycle digit period, wrap every 128
    bri = 3'd7;
    do_reset();
    tick();
    check("b7_lit0_frame", 32'(frame_o), 32'h06FE);
    for (int i = 0; i < 4; i++) begin
      next_valid(n, f);
      check("b7_delay", 32'(n), 32'd32);
      check("b7_frame", 32'(f), 32'(exp_seq[i]));
    end
    check("b7_wrap_pulse", 32'(scan_wrap_o), 32'd1);
    check("b7_wrap_digit", 32'(digit_o), 32'd0);
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (scan_wrap_o) cnt++;
    end
    check("b7_wrap_count", 32'(cnt), 32'd1);
    check("b7_wrap_frame", 32'(frame_o), 32'h06FE);

    // Colon on digit 1 and blink on digit 0
    d1 = 4'd0; colon = 1'b1; bmask = 4'b0001; bphase = 1'b1;
    do_reset();
    tick();
    check("blink_frame", 32'(frame_o), 32'h00FE);
    next_valid(n, f);
    check("colon_frame", 32'(f), 32'hBFFD);
    d1 = 4'd2; colon = 1'b0; bmask = 4'b0000; bphase = 1'b0;

    // Stall in LOAD with a digit change mid-stall
    ready = 1'b0;
    do_reset();
    tick();
    check("stall_frame0", 32'(frame_o), 32'h06FE);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 25) d0 = 4'd9;
      if (frame_o != 16'h06FE || !frame_valid_o) cnt++;
    end
    check("stall_hold", 32'(cnt), 32'd0);
    ready = 1'b1;
    tick();
    check("stall_one_xfer", 32'(frame_valid_o), 32'd0);
    next_valid(n, f);
    check("stall_next_delay", 32'(n), 32'd31);
    check("stall_next_frame", 32'(f), 32'h5BFD);
    next_valid(n, f);
    next_valid(n, f);
    next_valid(n, f);
    check("stall_new_digit0", 32'(f), 32'h6FFE);
    d0 = 4'd1;

    // Stall in BLANK past the period end
    bri = 3'd3;
    do_reset();
    tick();
    next_valid(n, f);
    check("bstall_blank_delay", 32'(n), 32'd16);
    check("bstall_blank_frame", 32'(f), 32'h00FF);
    ready = 1'b0;
    repeat (20) tick();
    check("bstall_hold_valid", 32'(frame_valid_o), 32'd1);
    check("bstall_hold_frame", 32'(frame_o), 32'h00FF);
    ready = 1'b1;
    tick();
    check("bstall_drop", 32'(frame_valid_o), 32'd0);
    tick();
    check("bstall_load_valid", 32'(frame_valid_o), 32'd1);
    check("bstall_load_frame", 32'(frame_o), 32'h5BFD);

    // Reset during ON of digit 2
    do_reset();
    tick();
    next_valid(n, f);
    next_valid(n, f);
    next_valid(n, f);
    next_valid(n, f);
    check("mid_digit2_frame", 32'(f), 32'h4FFB);
    check("mid_digit2_idx", 32'(digit_o), 32'd2);
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_frame", 32'(frame_o), 32'h00FF);
    check("mid_rst_valid", 32'(frame_valid_o), 32'd0);
    check("mid_rst_digit", 32'(digit_o), 32'd0);
    check("mid_rst_wrap", 32'(scan_wrap_o), 32'd0);
    tick();
    tick();
    check("mid_rst_still", 32'(frame_valid_o), 32'd0);
    rst_n = 1'b1;
    tick();
    check("restart_valid", 32'(frame_valid_o), 32'd1);
    check("restart_frame", 32'(frame_o), 32'h06FE);
    check("restart_digit", 32'(digit_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
